// File: rtl/jump_target_encoder_if.sv
// rtl/jump_target_encoder_if.sv - request/result bundle for jump_target_encoder
//
// Purpose: groups the request handshake, the result handshake and the result
//          fields of the jump-target encoder.
// Signals:
//   in_valid / in_ready    request handshake (master drives in_valid)
//   target, pc, link       request payload: byte target, jump PC, 1 = JAL
//   out_valid / out_ready  result handshake (slave drives out_valid)
//   instr_index            target[27:2]
//   instr_word             full J-type word (zero unless JTE_JWORD_EN)
//   err_align, err_region  per-result error flags
//   err_count              saturating count of errored results delivered
// Modports: master = requester/consumer side, slave = encoder side.

interface jump_target_encoder_if #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = ADDR_W - 6,
  parameter int ERR_CNT_W = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    target;
  logic [ADDR_W-1:0]    pc;
  logic                 link;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     instr_index;
  logic [ADDR_W-1:0]    instr_word;
  logic                 err_align;
  logic                 err_region;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, target, pc, link, out_ready,
    input  in_ready, out_valid, instr_index, instr_word, err_align, err_region, err_count
  );

  modport slave (
    input  in_valid, target, pc, link, out_ready,
    output in_ready, out_valid, instr_index, instr_word, err_align, err_region, err_count
  );
endinterface

// File: rtl/jump_target_encoder.sv
// rtl/jump_target_encoder.sv - byte jump target to J-type instr_index encoder
//
// Purpose: converts a 32-bit byte jump target into the 26-bit J-type
//          instr_index (target[27:2]), flags misalignment and 256 MB region
//          mismatch against PC+4, and counts errored results. Two-stage
//          valid/ready pipeline; errored results still flow through.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     jump_target_encoder_if.slave (request, result, error flags, count)
// Configuration macro: JTE_JWORD_EN - when defined, instr_word carries the full
//   J/JAL word registered alongside instr_index; otherwise it is tied to zero.

module jump_target_encoder #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = ADDR_W - 6,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  jump_target_encoder_if.slave    bus
);

  // Stage 1: captured request with PC+4 precomputed.
  logic                 s1_valid;
  logic [ADDR_W-1:0]    s1_target;
  logic [ADDR_W-1:0]    s1_pc_plus4;
  logic                 s1_link;

  // Stage 2: result register, drives the outputs directly.
  logic                 s2_valid;
  logic [IDX_W-1:0]     s2_index;
  logic                 s2_err_align;
  logic                 s2_err_region;
  logic [ERR_CNT_W-1:0] err_cnt;

  logic s2_transfer;
  logic s1_advance;
  logic in_fire;

  assign s2_transfer = s2_valid & bus.out_ready;
  // s1 may move into s2 when s2 is empty or is emptying this cycle.
  assign s1_advance  = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s1_advance;
  assign in_fire     = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_target   <= '0;
      s1_pc_plus4 <= '0;
      s1_link     <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid    <= 1'b1;
        s1_target   <= bus.target;
        s1_pc_plus4 <= bus.pc + ADDR_W'(4);  // wraps at 2^32
        s1_link     <= bus.link;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      s2_index      <= '0;
      s2_err_align  <= 1'b0;
      s2_err_region <= 1'b0;
    end else begin
      // A reload takes priority over a plain drain so that a same-cycle
      // transfer plus advance keeps s2 full with the next result.
      if (s1_advance) begin
        s2_valid      <= 1'b1;
        s2_index      <= s1_target[IDX_W+1:2];
        s2_err_align  <= |s1_target[1:0];
        s2_err_region <= s1_target[ADDR_W-1:ADDR_W-4] != s1_pc_plus4[ADDR_W-1:ADDR_W-4];
      end else if (s2_transfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s2_transfer && (s2_err_align || s2_err_region) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

`ifdef JTE_JWORD_EN
  logic [ADDR_W-1:0] s2_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_word <= '0;
    end else if (s1_advance) begin
      // opcode 6'h03 = JAL, 6'h02 = J
      s2_word <= {(s1_link ? 6'h03 : 6'h02), s1_target[IDX_W+1:2]};
    end
  end

  assign bus.instr_word = s2_word;
`else
  logic unused_link;
  assign unused_link    = s1_link;
  assign bus.instr_word = '0;
`endif

  assign bus.out_valid   = s2_valid;
  assign bus.instr_index = s2_index;
  assign bus.err_align   = s2_err_align;
  assign bus.err_region  = s2_err_region;
  assign bus.err_count   = err_cnt;

endmodule

// File: tb/tb_jump_target_encoder.sv
// tb/tb_jump_target_encoder.sv - scoreboard bench for jump_target_encoder

module tb_jump_target_encoder;

  typedef struct {
    logic [25:0] idx;
    logic        align;
    logic        region;
    logic [31:0] word;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;
  int   exp_err;
  exp_t q[$];

  jump_target_encoder_if bus ();

  jump_target_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] t, input logic [31:0] p, input logic l);
    exp_t e;
    logic [31:0] p4;
    p4       = p + 32'd4;
    e.idx    = t[27:2];
    e.align  = (t[1:0] != 2'b00);
    e.region = (t[31:28] != p4[31:28]);
`ifdef JTE_JWORD_EN
    e.word   = {(l ? 6'h03 : 6'h02), t[27:2]};
`else
    e.word   = 32'h0;
`endif
    return e;
  endfunction

  // Scoreboard: occupancy and ordering checks, push on accept, pop on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
      chk("err_count", 32'(bus.err_count), 32'(exp_err));
      if (q.size() == 0) begin
        chk("idle_valid", 32'(bus.out_valid), 32'h0);
      end else if (bus.out_valid) begin
        chk("instr_index", 32'(bus.instr_index), 32'(q[0].idx));
        chk("err_align", 32'(bus.err_align), 32'(q[0].align));
        chk("err_region", 32'(bus.err_region), 32'(q[0].region));
        chk("instr_word", bus.instr_word, q[0].word);
        if (bus.out_ready) begin
          if ((q[0].align || q[0].region) && exp_err < 255) exp_err++;
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.target, bus.pc, bus.link));
    end
  end

  task automatic send(input logic [31:0] t, input logic [31:0] p, input logic l);
    bus.in_valid = 1'b1;
    bus.target   = t;
    bus.pc       = p;
    bus.link     = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'h1, 32'h0);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    exp_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.target    = '0;
    bus.pc        = '0;
    bus.link      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_instr_index", 32'(bus.instr_index), 32'h0);
    chk("rst_instr_word", bus.instr_word, 32'h0);
    chk("rst_err_align", 32'(bus.err_align), 32'h0);
    chk("rst_err_region", 32'(bus.err_region), 32'h0);
    chk("rst_err_count", 32'(bus.err_count), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Basic encode and two-cycle latency.
    bus.in_valid = 1'b1;
    bus.target   = 32'h0040_0020;
    bus.pc       = 32'h0040_0000;
    bus.link     = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(bus.out_valid), 32'h1);
    chk("t2_index", 32'(bus.instr_index), 32'h0010_0008);
`ifdef JTE_JWORD_EN
    chk("t2_word", bus.instr_word, 32'h0810_0008);
`endif
    drain();

    // Misaligned and out-of-region target.
    send(32'h1000_0006, 32'h0000_0100, 1'b1);
    drain();
    chk("t3_err_count", 32'(bus.err_count), 32'h1);

    // PC+4 wraps to zero, region 0 matches.
    send(32'h0000_0010, 32'hFFFF_FFFC, 1'b0);
    drain();
    chk("t4_err_count", 32'(bus.err_count), 32'h1);

    // Back-to-back burst with a three-cycle consumer stall.
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'h0040_1000 + 32'(i * 4), 32'h0040_0000, i[0]);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random back-pressure.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [31:0] t;
          logic [31:0] p;
          t = $urandom;
          p = $urandom;
          if ($urandom_range(0, 1) == 0) p = {t[31:28], p[27:0]};
          if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
          send(t, p, 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Reset with both stages full and the consumer stalled.
    send(32'h1000_0006, 32'h0000_0100, 1'b1);
    drain();
    bus.out_ready = 1'b0;
    send(32'h0040_0020, 32'h0040_0000, 1'b0);
    send(32'h0040_0024, 32'h0040_0000, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_err_count", 32'(bus.err_count), 32'h0);
    q.delete();
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_no_out", 32'(bus.out_valid), 32'h0);
    @(posedge clk);
    #1;

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) send(32'h1000_0006 + 32'(i * 16), 32'h0000_0000, 1'b0);
    drain();
    chk("sat_err_count", 32'(bus.err_count), 32'h0000_00FF);
    send(32'h1000_0005, 32'h0000_0000, 1'b0);
    drain();
    chk("sat_hold", 32'(bus.err_count), 32'h0000_00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
